// File: rtl/t_ff_counter_if.sv
// Control and observation bundle for the T-stage counter.
// The master drives the strobes and load value; the slave (counter) returns q, t_vec and tc.
interface t_ff_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t_vec;
  logic             tc;

  modport master (
    output en, up_dn, load, d,
    input  q, t_vec, tc
  );

  modport slave (
    input  en, up_dn, load, d,
    output q, t_vec, tc
  );
endinterface

// File: rtl/t_ff_counter.sv
// Modulo-N up/down counter built from T stages: q <= q ^ t_vec each edge, with load and terminal count.
// q updates one clock after inputs are sampled; t_vec and tc are combinational, so there is no backpressure.
module t_ff_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic           clk,
  input  logic           rst,
  t_ff_counter_if.slave  bus
);

  localparam int W1 = WIDTH + 1;
  // Extra bit keeps MODULUS-1 and q+1 exact when MODULUS = 2^WIDTH.
  localparam logic [WIDTH:0] LAST = W1'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE  = W1'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_d_ext;
  logic [WIDTH:0]   w_next_ext;
  logic [WIDTH-1:0] w_t_vec;
  logic             w_at_top;
  logic             w_at_zero;
  logic             w_tc;

  always_comb begin
    w_q_ext    = {1'b0, r_q};
    w_d_ext    = {1'b0, bus.d};
    w_at_top   = (w_q_ext == LAST);
    w_at_zero  = (w_q_ext == '0);
    w_next_ext = w_q_ext;
    if (rst) begin
      w_next_ext = '0;
    end else if (bus.load) begin
      w_next_ext = (w_d_ext > LAST) ? LAST : w_d_ext;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        w_next_ext = w_at_top ? '0 : (w_q_ext + ONE);
      end else begin
        w_next_ext = w_at_zero ? LAST : (w_q_ext - ONE);
      end
    end
    w_t_vec = r_q ^ w_next_ext[WIDTH-1:0];
    w_tc    = bus.en & ~bus.load & ~rst &
              ((bus.up_dn & w_at_top) | (~bus.up_dn & w_at_zero));
  end

  // The explicit clear keeps simulation out of X when q starts unknown; logically identical to q ^ t_vec.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_q ^ w_t_vec;
    end
  end

  assign bus.q     = r_q;
  assign bus.t_vec = w_t_vec;
  assign bus.tc    = w_tc;

  a_next_in_range: assert property (@(posedge clk) w_next_ext <= LAST);

endmodule

// File: doc/t_ff_counter.md
Name: t_ff_counter

Overview:
- Synchronous N-bit up/down counter built from edge-triggered T flip-flop stages.
- Sits directly downstream of the toggle cell: each bit is a T stage, and the block derives the per-bit toggle enables (t_vec) that drive those stages.
- Adds parallel load, a programmable modulus and a terminal-count output.
- Used as the reference counter for the sequential-circuits section and as a divide-by-N clock-enable source.

Parameters:
- WIDTH, 4, number of T stages / counter bits (1..16).
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH.

Ports:
- clk  input  1  rising-edge clock for all T stages.
- rst  input  1  reset, synchronous, active-high; clears counter.
- en  input  1  count enable; advances one step per clk when high.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load strobe.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  registered count value.
- t_vec  output  WIDTH  combinational per-stage toggle enables for the current cycle.
- tc  output  1  combinational terminal count, asserted when the next enabled step wraps.

Behaviour:
- State is held only in the WIDTH T stages. Every rising clk: q <= q ^ t_vec.
- No other storage; no latches; no combinational loops.
- Priority per cycle: rst > load > en > hold.

rst:
- When rst is high at a rising edge, q <= 0.
- tc and t_vec reflect q = 0 on the following cycle.
- rst mid-count discards the count; no partial toggle.

load (rst low):
- next = d when d <= MODULUS-1; otherwise next = MODULUS-1 (clamped).
- t_vec = q ^ next.
- load overrides en and up_dn.

Count (rst low, load low, en high):
- Up: next = (q == MODULUS-1) ? 0 : q+1.
- Down: next = (q == 0) ? MODULUS-1 : q-1.
- t_vec = q ^ next. For power-of-two MODULUS this equals the classic T-counter pattern: up toggles bit i when bits 0..i-1 are all 1; down toggles when they are all 0.

Hold (en low, load low):
- t_vec = 0 and q is unchanged.

tc:
- tc = en & ~load & ~rst & ((up_dn & q == MODULUS-1) | (~up_dn & q == 0)).
- Asserts for exactly the cycle before the wrap edge.
- Low while en is low.

Latency and direction:
- q updates one clock after the inputs are sampled. No pipeline beyond that.
- up_dn may change on any cycle; it takes effect at the next edge.
- Toggling up_dn at a boundary is legal and must not skip or duplicate values.

Arithmetic:
- Comparisons and increment/decrement are computed at WIDTH+1 bits internally to avoid overflow when MODULUS = 2^WIDTH.
- q never leaves the range 0..MODULUS-1 after reset.

Reset value of outputs:
- q = 0.
- t_vec = 0 when en = 0.
- tc = 0 unless en = 1 and up_dn = 0, since q = 0 is the down wrap point.

Test Plan:
- WIDTH=4, MODULUS=16. rst=1 for 2 clocks, then en=1, up_dn=1 for 17 clocks -> q runs 0,1,…,15,0. tc is high only while q=15. t_vec=4'b1111 at q=15 and 4'b0001 at q=0.
- MODULUS=10, count up from 0 -> q runs 0..9,0. At q=9: t_vec=4'b1001 and tc=1. q never reaches 10.
- MODULUS=10, en=1, up_dn=0 from q=0 -> q runs 0,9,8,…,0. tc is high at q=0. At the first edge t_vec=4'b1001.
- load with d=5 while en=1 -> q=5 next clock, count resumes 6,7. load with d=12 at MODULUS=10 -> q=9. load and rst asserted together -> q=0.
- With q=6, deassert en for 3 clocks -> q holds 6, t_vec=0, tc=0. Reassert en -> q=7.
- rst asserted mid-count at q=7 with en=1 -> q=0 on the next edge. Count restarts 1,2 after rst drops. Flip up_dn at q=15: the next value is 14, with no wrap.
